// File: rtl/quadratic_root_solver_if.sv
// Request/response bundle for the quadratic root solver: the operand
// request (enable, start, coefficients, target) and the result
// (busy, done, found, exact, x_out).
interface quadratic_root_solver_if #(
  parameter int DW = 8,
  parameter int YW = 3*DW
);
  logic          enable;
  logic          start;
  logic [DW-1:0] in_a;
  logic [DW-1:0] in_b;
  logic [DW-1:0] in_c;
  logic [YW-1:0] in_y;
  logic          busy;
  logic          done;
  logic          found;
  logic          exact;
  logic [DW-1:0] x_out;

  modport master (
    output enable, start, in_a, in_b, in_c, in_y,
    input  busy, done, found, exact, x_out
  );

  modport slave (
    input  enable, start, in_a, in_b, in_c, in_y,
    output busy, done, found, exact, x_out
  );
endinterface

// File: rtl/quadratic_root_solver.sv
// Floor root of a*x^2 + b*x + c <= y by MSB-first binary search.
// Each trial bit takes two cycles through a Horner evaluator:
// EVAL1 registers R = a*t + b, and EVAL2 forms P = R*t + c and compares it with y.
// YW is wide enough for the largest P, so the comparison never wraps.
module quadratic_root_solver #(
  parameter int DW = 8,
  parameter int YW = 3*DW
) (
  input  logic                   clk,
  input  logic                   reset,
  quadratic_root_solver_if.slave bus
);
  localparam int BW = (DW > 1) ? $clog2(DW) : 1;
  localparam int RW = 2*DW + 1;

  typedef enum logic [1:0] {IDLE, CHECK, EVAL1, EVAL2} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] a_q, b_q, c_q;
  logic [YW-1:0] y_q;
  logic [DW-1:0] x_acc;
  logic          exact_acc;
  logic [BW-1:0] bit_q;
  logic [RW-1:0] r_q;
  logic          busy_q, done_q, found_q, exact_q;
  logic [DW-1:0] x_q;

  logic [DW-1:0] t;
  logic [RW-1:0] r_nxt;
  logic [YW-1:0] p_nxt;
  logic          p_le, p_eq, c_gt_y, last;

  // Trial value and the Horner stages, all computed at full width
  always_comb begin
    t      = x_acc | (DW'(1) << bit_q);
    r_nxt  = RW'(a_q) * RW'(t) + RW'(b_q);
    p_nxt  = YW'(r_q) * YW'(t) + YW'(c_q);
    p_le   = (p_nxt <= y_q);
    p_eq   = (p_nxt == y_q);
    c_gt_y = (YW'(c_q) > y_q);
    last   = (bit_q == '0);
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CHECK;
      CHECK:   state_d = c_gt_y ? IDLE : EVAL1;
      EVAL1:   state_d = EVAL2;
      EVAL2:   state_d = last ? IDLE : EVAL1;
      default: state_d = IDLE;
    endcase
  end

  // State register; holds while enable is low
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)          state_q <= IDLE;
    else if (bus.enable) state_q <= state_d;
  end

  // Operand latch, search accumulator and result registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q       <= '0;
      b_q       <= '0;
      c_q       <= '0;
      y_q       <= '0;
      x_acc     <= '0;
      exact_acc <= 1'b0;
      bit_q     <= '0;
      r_q       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      found_q   <= 1'b0;
      exact_q   <= 1'b0;
      x_q       <= '0;
    end else if (bus.enable) begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: if (bus.start) begin
          a_q    <= bus.in_a;
          b_q    <= bus.in_b;
          c_q    <= bus.in_c;
          y_q    <= bus.in_y;
          x_acc  <= '0;
          bit_q  <= BW'(DW-1);
          busy_q <= 1'b1;
        end
        CHECK: begin
          if (c_gt_y) begin
            // Even x=0 overshoots: no root
            found_q <= 1'b0;
            x_q     <= '0;
            exact_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            exact_acc <= (YW'(c_q) == y_q);
          end
        end
        EVAL1: r_q <= r_nxt;
        EVAL2: begin
          if (p_le) begin
            x_acc     <= t;
            exact_acc <= p_eq;
          end
          if (last) begin
            x_q     <= p_le ? t : x_acc;
            exact_q <= p_le ? p_eq : exact_acc;
            found_q <= 1'b1;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
          end else begin
            bit_q <= bit_q - BW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.found = found_q;
  assign bus.exact = exact_q;
  assign bus.x_out = x_q;
endmodule

// File: tb/tb_quadratic_root_solver.sv
// Directed bench for quadratic_root_solver: hand-computed roots, latency,
// busy width, start/enable handling and asynchronous reset.
module tb_quadratic_root_solver;
  localparam int DW = 8;
  localparam int YW = 24;

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;

  quadratic_root_solver_if #(.DW(DW), .YW(YW)) bus();
  quadratic_root_solver #(.DW(DW), .YW(YW)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One search: start pulse, count edges to done (enable dropped for
  // 3 edges after edge 'stall' when stall > 0), then check the result
  task automatic run(input string tag, input int a, input int b, input int c, input int y,
                     input int ex, input int ef, input int ee, input int el, input int stall);
    int cycles, busy_n;
    bus.in_a = DW'(a); bus.in_b = DW'(b); bus.in_c = DW'(c); bus.in_y = YW'(y);
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    cycles = 0; busy_n = 0;
    while (!bus.done && cycles < 60) begin
      if (bus.busy) busy_n++;
      @(posedge clk); #1;
      cycles++;
      if (stall > 0 && cycles == stall) bus.enable = 1'b0;
      if (stall > 0 && cycles == stall + 3) bus.enable = 1'b1;
    end
    chk({tag, ".latency"}, cycles, el);
    chk({tag, ".busy_cycles"}, busy_n, el);
    chk({tag, ".busy_at_done"}, bus.busy, 0);
    chk({tag, ".x_out"}, bus.x_out, ex);
    chk({tag, ".found"}, bus.found, ef);
    chk({tag, ".exact"}, bus.exact, ee);
    @(posedge clk); #1;
    chk({tag, ".done_pulse"}, bus.done, 0);
    chk({tag, ".x_hold"}, bus.x_out, ex);
  endtask

  initial begin
    int cycles;
    reset = 1'b0;
    bus.enable = 1'b1; bus.start = 1'b0;
    bus.in_a = '0; bus.in_b = '0; bus.in_c = '0; bus.in_y = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset.busy", bus.busy, 0);
    chk("reset.done", bus.done, 0);
    chk("reset.found", bus.found, 0);
    chk("reset.exact", bus.exact, 0);
    chk("reset.x_out", bus.x_out, 0);
    reset = 1'b1;
    @(posedge clk); #1;

    run("sq144",   1, 0, 0, 144,      12,  1, 1, 17, 0);
    run("y100",    1, 2, 1, 100,      9,   1, 1, 17, 0);
    run("y99",     1, 2, 1, 99,       8,   1, 0, 17, 0);
    run("noroot",  3, 4, 50, 10,      0,   0, 0, 1,  0);
    run("maxall",  255, 255, 255, 16777215, 255, 1, 0, 17, 0);
    run("const5",  0, 0, 5, 5,        255, 1, 1, 17, 0);
    run("zeros",   0, 0, 0, 0,        255, 1, 1, 17, 0);

    // Start held for the whole search, extra pulse and operand changes mid-search
    bus.in_a = 8'd1; bus.in_b = 8'd0; bus.in_c = 8'd0; bus.in_y = 24'd144;
    bus.start = 1'b1;
    @(posedge clk); #1;
    cycles = 0;
    while (!bus.done && cycles < 60) begin
      if (cycles == 4) begin bus.in_y = 24'd0; bus.in_a = 8'd7; end
      if (cycles == 6) bus.start = 1'b0;
      if (cycles == 7) bus.start = 1'b1;
      @(posedge clk); #1;
      cycles++;
    end
    bus.start = 1'b0;
    chk("held.latency", cycles, 17);
    chk("held.x_out", bus.x_out, 12);
    chk("held.exact", bus.exact, 1);
    @(posedge clk); #1;
    chk("held.no_restart", bus.busy, 0);
    chk("held.done_clear", bus.done, 0);

    // Enable low for 3 cycles mid-search stretches latency by 3
    run("stall", 1, 2, 1, 100, 9, 1, 1, 20, 5);

    // done holds while enable is low
    bus.in_a = 8'd3; bus.in_b = 8'd4; bus.in_c = 8'd50; bus.in_y = 24'd10;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    @(posedge clk); #1;
    chk("hold.done", bus.done, 1);
    bus.enable = 1'b0;
    @(posedge clk); #1;
    chk("hold.done_en0", bus.done, 1);
    bus.enable = 1'b1;
    @(posedge clk); #1;
    chk("hold.done_en1", bus.done, 0);

    // Prime nonzero results, then reset mid-search with no clock edge
    run("prime", 1, 0, 0, 144, 12, 1, 1, 17, 0);
    bus.in_a = 8'd1; bus.in_b = 8'd0; bus.in_c = 8'd0; bus.in_y = 24'd144;
    bus.start = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("arst.pre_busy", bus.busy, 1);
    reset = 1'b0;
    #1;
    chk("arst.busy", bus.busy, 0);
    chk("arst.done", bus.done, 0);
    chk("arst.x_out", bus.x_out, 0);
    chk("arst.found", bus.found, 0);
    chk("arst.exact", bus.exact, 0);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    run("post", 1, 0, 0, 255, 15, 1, 0, 17, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
